// File: rtl/wb_data_stage.sv
// Registered write-back data select between the MEM stage and the register file.
// A load whose data is late waits in WAIT_MEM for a bounded number of cycles.
module wb_data_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int PC_SHIFT    = 2,
  parameter int MEM_TIMEOUT = 15,
  parameter int ZERO_REG_RO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        sel,
  input  logic              reg_we_in,
  input  logic [REG_AW-1:0] dest_in,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [DATA_W-1:0] pc_data,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              mem_timeout_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] dest_q, dest_d;
  logic              we_lat_q, we_lat_d;
  logic              wb_we_q, wb_we_d;
  logic [REG_AW-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] src_val;

  // Register 0 may be hard-wired; its write strobe is dropped but data still moves.
  function automatic logic gate_we(input logic we, input logic [REG_AW-1:0] addr);
    return we && !((ZERO_REG_RO != 0) && (addr == '0));
  endfunction

  always_comb begin
    src_val = alu_data;
    case (sel)
      2'b01:   src_val = mem_data;
      2'b10:   src_val = pc_data >> PC_SHIFT;
      default: src_val = alu_data;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dest_d    = dest_q;
    we_lat_d  = we_lat_q;
    wb_we_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if ((sel == 2'b01) && !mem_valid) begin
            dest_d   = dest_in;
            we_lat_d = reg_we_in;
            cnt_d    = '0;
            state_d  = S_WAIT_MEM;
          end else begin
            wb_data_d = src_val;
            wb_addr_d = dest_in;
            wb_we_d   = gate_we(reg_we_in, dest_in);
          end
        end
      end
      S_WAIT_MEM: begin
        // Data arriving on the last allowed cycle still wins over the timeout.
        if (mem_valid) begin
          wb_data_d = mem_data;
          wb_addr_d = dest_q;
          wb_we_d   = gate_we(we_lat_q, dest_q);
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dest_q    <= '0;
      we_lat_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dest_q    <= dest_d;
      we_lat_q  <= we_lat_d;
      wb_we_q   <= wb_we_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      err_q     <= err_d;
    end
  end

  assign in_ready        = (state_q == S_IDLE);
  assign busy            = (state_q == S_WAIT_MEM);
  assign wb_we           = wb_we_q;
  assign wb_addr         = wb_addr_q;
  assign wb_data         = wb_data_q;
  assign mem_timeout_err = err_q;

endmodule

// File: tb/tb_wb_data_stage.sv
// Scoreboard bench for wb_data_stage: two instances (PC_SHIFT 2 and 0, MEM_TIMEOUT 4)
// share stimulus; a negedge monitor pops expected writes on each wb_we pulse.
module tb_wb_data_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, reg_we_in, mem_valid;
  logic [1:0]  sel;
  logic [4:0]  dest_in;
  logic [31:0] alu_data, pc_data, mem_data;

  logic        in_ready, wb_we, busy, err;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        in_ready0, wb_we0, busy0, err0;
  logic [4:0]  wb_addr0;
  logic [31:0] wb_data0;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] data0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_data_stage #(.DATA_W(32), .REG_AW(5), .PC_SHIFT(2), .MEM_TIMEOUT(4), .ZERO_REG_RO(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .reg_we_in(reg_we_in), .dest_in(dest_in), .alu_data(alu_data), .pc_data(pc_data),
    .mem_data(mem_data), .mem_valid(mem_valid), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy(busy), .mem_timeout_err(err)
  );

  wb_data_stage #(.DATA_W(32), .REG_AW(5), .PC_SHIFT(0), .MEM_TIMEOUT(4), .ZERO_REG_RO(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .sel(sel),
    .reg_we_in(reg_we_in), .dest_in(dest_in), .alu_data(alu_data), .pc_data(pc_data),
    .mem_data(mem_data), .mem_valid(mem_valid), .wb_we(wb_we0), .wb_addr(wb_addr0),
    .wb_data(wb_data0), .busy(busy0), .mem_timeout_err(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic we, input logic [4:0] d,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] mem,
                       input logic mv);
    in_valid  = v;
    sel       = s;
    reg_we_in = we;
    dest_in   = d;
    alu_data  = alu;
    pc_data   = pc;
    mem_data  = mem;
    mem_valid = mv;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d, input logic [31:0] d0);
    exp_t e;
    e.addr  = a;
    e.data  = d;
    e.data0 = d0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst && wb_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got wb_we=1 addr=%0d data=0x%08h, expected no write",
                 wb_addr, wb_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wb_addr", {27'd0, wb_addr}, {27'd0, mon_e.addr});
        chk("wb_data", wb_data, mon_e.data);
        chk("wb_we_pc0", {31'd0, wb_we0}, 32'd1);
        chk("wb_addr_pc0", {27'd0, wb_addr0}, {27'd0, mon_e.addr});
        chk("wb_data_pc0", wb_data0, mon_e.data0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pc0_ready", {30'd0, in_ready0, busy0}, 32'd2);
    rst = 1'b0;

    // ALU source, one-cycle latency, pulse then hold
    drive(1'b1, 2'b00, 1'b1, 5'd3, 32'h0000_1234, 32'd0, 32'd0, 1'b0);
    push(5'd3, 32'h0000_1234, 32'h0000_1234);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("t1_we_low", {31'd0, wb_we}, 32'd0);
    chk("t1_addr_hold", {27'd0, wb_addr}, 32'd3);
    chk("t1_data_hold", wb_data, 32'h0000_1234);

    // PC source, shifted by 2 and by 0
    drive(1'b1, 2'b10, 1'b1, 5'd31, 32'd0, 32'h0000_0040, 32'd0, 1'b0);
    push(5'd31, 32'h0000_0010, 32'h0000_0040);
    @(negedge clk);
    idle();
    @(negedge clk);

    // Back-to-back accepts; sel=11 behaves as ALU
    drive(1'b1, 2'b00, 1'b1, 5'd1, 32'h0000_000A, 32'd0, 32'd0, 1'b0);
    push(5'd1, 32'h0000_000A, 32'h0000_000A);
    @(negedge clk);
    drive(1'b1, 2'b11, 1'b1, 5'd2, 32'h0000_000B, 32'h0000_0100, 32'd0, 1'b0);
    push(5'd2, 32'h0000_000B, 32'h0000_000B);
    @(negedge clk);
    idle();
    @(negedge clk);

    // MEM load stalls 3 cycles; next request held during stall
    drive(1'b1, 2'b01, 1'b1, 5'd7, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b1, 5'd9, 32'h0000_0055, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("t3_busy", {31'd0, busy}, 32'd1);
      chk("t3_not_ready", {31'd0, in_ready}, 32'd0);
      if (i < 2) @(negedge clk);
    end
    drive(1'b1, 2'b00, 1'b1, 5'd9, 32'h0000_0055, 32'd0, 32'hDEAD_BEEF, 1'b1);
    push(5'd7, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t3_ready_again", {31'd0, in_ready}, 32'd1);
    chk("t3_busy_low", {31'd0, busy}, 32'd0);
    drive(1'b1, 2'b00, 1'b1, 5'd9, 32'h0000_0055, 32'd0, 32'd0, 1'b0);
    push(5'd9, 32'h0000_0055, 32'h0000_0055);
    @(negedge clk);
    idle();
    @(negedge clk);

    // MEM timeout after 4 wait cycles, sticky error
    drive(1'b1, 2'b01, 1'b1, 5'd12, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("t4_busy_last", {31'd0, busy}, 32'd1);
    chk("t4_no_err_yet", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    chk("t4_busy_low", {31'd0, busy}, 32'd0);
    chk("t4_data_held", wb_data, 32'h0000_0055);
    chk("t4_addr_held", {27'd0, wb_addr}, 32'd9);
    drive(1'b1, 2'b00, 1'b1, 5'd4, 32'h0000_0077, 32'd0, 32'd0, 1'b0);
    push(5'd4, 32'h0000_0077, 32'h0000_0077);
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("t4_err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_err_cleared", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // MEM data on the 4th wait cycle wins over timeout
    drive(1'b1, 2'b01, 1'b1, 5'd13, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    drive(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0, 32'hCAFE_F00D, 1'b1);
    push(5'd13, 32'hCAFE_F00D, 32'hCAFE_F00D);
    @(negedge clk);
    idle();
    chk("t4b_no_err", {31'd0, err}, 32'd0);
    chk("t4b_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Write gating: register 0 and reg_we_in=0
    drive(1'b1, 2'b00, 1'b1, 5'd0, 32'h0000_0099, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    idle();
    chk("t5_r0_we", {31'd0, wb_we}, 32'd0);
    chk("t5_r0_addr", {27'd0, wb_addr}, 32'd0);
    chk("t5_r0_data", wb_data, 32'h0000_0099);
    drive(1'b1, 2'b00, 1'b0, 5'd5, 32'h0000_00AB, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    idle();
    chk("t5_nowe_we", {31'd0, wb_we}, 32'd0);
    chk("t5_nowe_addr", {27'd0, wb_addr}, 32'd5);
    chk("t5_nowe_data", wb_data, 32'h0000_00AB);
    @(negedge clk);

    // Asynchronous reset in the middle of a stall
    drive(1'b1, 2'b01, 1'b1, 5'd20, 32'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    idle();
    chk("t6_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_addr", {27'd0, wb_addr}, 32'd0);
    chk("t6_async_data", wb_data, 32'd0);
    chk("t6_async_busy", {31'd0, busy}, 32'd0);
    chk("t6_async_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 32'd0, 32'h0000_1111, 1'b1);
    repeat (2) @(negedge clk);
    idle();
    chk("t6_no_write_we", {31'd0, wb_we}, 32'd0);
    chk("t6_no_write_data", wb_data, 32'd0);
    @(negedge clk);

    chk("sb_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
